// File: rtl/spacecraft_led_ctrl.sv
// Spacecraft LED/status-indicator peripheral on an Avalon-MM slave port.
// Each channel can be off, on, blinking or PWM-dimmed. A per-channel one-shot
// pulse can force the channel lit for a programmable number of ticks.
module spacecraft_led_ctrl #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [2:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  output logic [NUM_LEDS-1:0] leds_readdata
);

  localparam int unsigned PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_TOP = PS_W'(PRESCALE - 1);

  typedef enum logic [2:0] {
    A_CTRL      = 3'd0,
    A_MODE      = 3'd1,
    A_DUTY      = 3'd2,
    A_BLINK     = 3'd3,
    A_PULSE_LEN = 3'd4,
    A_PULSE     = 3'd5,
    A_LEDS      = 3'd6,
    A_RSVD      = 3'd7
  } reg_addr_e;

  reg_addr_e addr;
  assign addr = reg_addr_e'(avs_address);

  // Register file
  logic                  en;
  logic [2*NUM_LEDS-1:0] mode;
  logic [PWM_BITS-1:0]   duty;
  logic [15:0]           blink_len;
  logic [15:0]           pulse_len;

  // Generators
  logic [PS_W-1:0]       presc;
  logic                  tick;
  logic [15:0]           blink_cnt;
  logic [15:0]           blink_top;
  logic                  blink_phase;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [15:0]           pulse_cnt [NUM_LEDS];
  logic [NUM_LEDS-1:0]   pulse_active;
  logic [NUM_LEDS-1:0]   mode_out;

  // Write decode
  logic wr_ctrl, wr_mode, wr_duty, wr_blink, wr_plen, wr_pulse;
  logic sync_wr;
  logic [31:0] rd_mux;

  // Only part of the write bus is stored for small parameterisations
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Decode write strobes per register
  always_comb begin
    wr_ctrl  = 1'b0;
    wr_mode  = 1'b0;
    wr_duty  = 1'b0;
    wr_blink = 1'b0;
    wr_plen  = 1'b0;
    wr_pulse = 1'b0;
    if (avs_write) begin
      case (addr)
        A_CTRL:      wr_ctrl  = 1'b1;
        A_MODE:      wr_mode  = 1'b1;
        A_DUTY:      wr_duty  = 1'b1;
        A_BLINK:     wr_blink = 1'b1;
        A_PULSE_LEN: wr_plen  = 1'b1;
        A_PULSE:     wr_pulse = 1'b1;
        default:     ;
      endcase
    end
  end

  assign sync_wr   = wr_ctrl & avs_writedata[1];
  assign tick      = en && (presc == PS_TOP);
  assign blink_top = (blink_len == 16'd0) ? 16'd0 : blink_len - 16'd1;

  // Control/configuration registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en        <= 1'b0;
      mode      <= '0;
      duty      <= '0;
      blink_len <= 16'd1;
      pulse_len <= '0;
    end else begin
      if (wr_ctrl)  en        <= avs_writedata[0];
      if (wr_mode)  mode      <= avs_writedata[2*NUM_LEDS-1:0];
      if (wr_duty)  duty      <= avs_writedata[PWM_BITS-1:0];
      if (wr_blink) blink_len <= avs_writedata[15:0];
      if (wr_plen)  pulse_len <= avs_writedata[15:0];
    end
  end

  // Tick prescaler, held at zero while disabled
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc <= '0;
    end else if (sync_wr || !en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // Blink half-period counter and phase; disabling restarts from the unlit phase
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (sync_wr || !en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt >= blink_top) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Free-running PWM counter
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_cnt <= '0;
    end else if (sync_wr) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // One-shot pulse counters; a reload takes priority over the tick decrement
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) pulse_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (!en) begin
          pulse_cnt[i] <= '0;
        end else if (wr_pulse && avs_writedata[i]) begin
          pulse_cnt[i] <= pulse_len;
        end else if (tick && (pulse_cnt[i] != 16'd0)) begin
          pulse_cnt[i] <= pulse_cnt[i] - 16'd1;
        end
      end
    end
  end

  // Per-channel mode output and pulse activity
  always_comb begin
    mode_out     = '0;
    pulse_active = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      pulse_active[i] = (pulse_cnt[i] != 16'd0);
      case (mode[2*i +: 2])
        2'b00:   mode_out[i] = 1'b0;
        2'b01:   mode_out[i] = 1'b1;
        2'b10:   mode_out[i] = blink_phase;
        default: mode_out[i] = (pwm_cnt < duty);
      endcase
    end
  end

  // Registered LED drive
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      leds_readdata <= '0;
    end else begin
      leds_readdata <= en ? (pulse_active | mode_out) : '0;
    end
  end

  // Read data selection from pre-write register values
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:      rd_mux[0]              = en;
      A_MODE:      rd_mux[2*NUM_LEDS-1:0] = mode;
      A_DUTY:      rd_mux[PWM_BITS-1:0]   = duty;
      A_BLINK:     rd_mux[15:0]           = blink_len;
      A_PULSE_LEN: rd_mux[15:0]           = pulse_len;
      A_PULSE:     rd_mux[NUM_LEDS-1:0]   = pulse_active;
      A_LEDS:      rd_mux[NUM_LEDS-1:0]   = leds_readdata;
      default:     ;
    endcase
  end

  // Fixed one-cycle read latency
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_spacecraft_led_ctrl.sv
// Directed self-checking bench for spacecraft_led_ctrl (PRESCALE=4, 4 LEDs, 4-bit PWM).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spacecraft_led_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [3:0]  leds_readdata;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  spacecraft_led_ctrl #(
    .NUM_LEDS (4),
    .PRESCALE (4),
    .PWM_BITS (4)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .leds_readdata     (leds_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_write = 1'b1;
    avs_address = a;
    avs_writedata = d;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
    exp_t x;
    x.tag = tag;
    x.data = e;
    exp_q.push_back(x);
    avs_read = 1'b1;
    avs_address = a;
    @(negedge clk_clk);
    avs_read = 1'b0;
  endtask

  task automatic chk_led(input logic [3:0] e, input string tag);
    check(tag, {28'd0, leds_readdata}, {28'd0, e});
  endtask

  // Read scoreboard: every valid read beat is matched to the oldest expectation
  always @(negedge clk_clk) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL rd_unexpected observed=0x%0h expected=none", avs_readdata);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check(x.tag, avs_readdata, x.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // 1. reset state and register defaults
    idle(3);
    chk_led(4'h0, "rst_leds");
    check("rst_valid", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    reset_reset_n = 1'b1;
    idle(1);
    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd1, 32'd0, "rst_mode");
    rd(3'd2, 32'd0, "rst_duty");
    rd(3'd3, 32'd1, "rst_blink");
    rd(3'd4, 32'd0, "rst_plen");
    rd(3'd5, 32'd0, "rst_pulse");
    rd(3'd6, 32'd0, "rst_leds_reg");
    rd(3'd7, 32'd0, "rst_rsvd");
    idle(1);
    chk_led(4'h0, "rst_leds_after");

    // 2. static on, two-edge write-to-LED latency
    wr(3'd0, 32'd1);
    wr(3'd1, 32'h01);
    chk_led(4'h0, "on_edge1");
    idle(1);
    chk_led(4'h1, "on_edge2");
    rd(3'd6, 32'd1, "on_leds_reg");
    rd(3'd7, 32'd0, "rsvd_read");

    // 3. blink with half-period 2 ticks, aligned by SYNC
    wr(3'd1, 32'h02);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd3);
    idle(7);
    chk_led(4'h0, "blink_n7");
    idle(1);
    chk_led(4'h0, "blink_n8");
    idle(1);
    chk_led(4'h1, "blink_n9");
    idle(7);
    chk_led(4'h1, "blink_n16");
    idle(1);
    chk_led(4'h0, "blink_n17");
    rd(3'd3, 32'd2, "blink_reg");
    rd(3'd0, 32'd1, "ctrl_sync_clear");

    // BLINK=0 behaves as 1: toggle every tick
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd3);
    idle(4);
    chk_led(4'h0, "blink0_n4");
    idle(1);
    chk_led(4'h1, "blink0_n5");
    idle(3);
    chk_led(4'h1, "blink0_n8");
    idle(1);
    chk_led(4'h0, "blink0_n9");

    // 4. PWM on ch3, duty 4 of 16
    wr(3'd2, 32'd4);
    wr(3'd1, 32'hC0);
    wr(3'd0, 32'd3);
    for (int k = 1; k <= 32; k++) begin
      idle(1);
      chk_led((((k - 1) % 16) < 4) ? 4'h8 : 4'h0, $sformatf("pwm4_n%0d", k));
    end
    wr(3'd2, 32'd0);
    idle(1);
    for (int k = 0; k < 16; k++) begin
      idle(1);
      chk_led(4'h0, $sformatf("pwm0_n%0d", k));
    end

    // 5. one-shot pulse of 3 ticks on ch1
    wr(3'd1, 32'h0);
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd3);
    wr(3'd5, 32'h2);
    chk_led(4'h0, "pulse_n1");
    idle(1);
    chk_led(4'h2, "pulse_n2");
    rd(3'd5, 32'h2, "pulse_mask_mid");
    idle(9);
    chk_led(4'h2, "pulse_n12");
    idle(1);
    chk_led(4'h0, "pulse_n13");
    rd(3'd5, 32'h0, "pulse_mask_done");

    // retrigger coinciding with the second tick
    wr(3'd0, 32'd3);
    wr(3'd5, 32'h2);
    idle(6);
    wr(3'd5, 32'h2);
    chk_led(4'h2, "retrig_n8");
    idle(8);
    chk_led(4'h2, "retrig_n16");
    idle(4);
    chk_led(4'h2, "retrig_n20");
    idle(1);
    chk_led(4'h0, "retrig_n21");

    // 6. disable during blink and pulse, then re-enable
    wr(3'd1, 32'h02);
    wr(3'd3, 32'd2);
    wr(3'd4, 32'd100);
    wr(3'd0, 32'd3);
    wr(3'd5, 32'h2);
    idle(8);
    chk_led(4'h3, "dis_before");
    wr(3'd0, 32'd0);
    chk_led(4'h3, "dis_edge1");
    idle(1);
    chk_led(4'h0, "dis_edge2");
    rd(3'd5, 32'h0, "dis_pulse_mask");
    wr(3'd5, 32'h2);
    rd(3'd5, 32'h0, "dis_pulse_ignored");
    rd(3'd6, 32'h0, "dis_leds_reg");
    wr(3'd0, 32'd1);
    chk_led(4'h0, "reen_n0");
    idle(8);
    chk_led(4'h0, "reen_n8");
    idle(1);
    chk_led(4'h1, "reen_n9");

    // asynchronous reset with a read in flight
    wr(3'd1, 32'h01);
    idle(2);
    chk_led(4'h1, "prerst_on");
    avs_read = 1'b1;
    avs_address = 3'd3;
    @(posedge clk_clk);
    #1;
    avs_read = 1'b0;
    check("inflight_valid", {31'd0, avs_readdatavalid}, 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, avs_readdatavalid}, 32'd0);
    check("arst_rdata", avs_readdata, 32'd0);
    chk_led(4'h0, "arst_leds");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    idle(1);
    rd(3'd0, 32'd0, "arst_ctrl");
    rd(3'd1, 32'd0, "arst_mode");
    rd(3'd3, 32'd1, "arst_blink");
    idle(3);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
